// File: rtl/uart_core_cfg.sv
// uart_core_cfg: UART with shared baud tick, runtime parity/stop config, TX and RX FSMs and an RX holding register
module uart_core_cfg #(
  parameter int DATA_W = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W = 16
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              rx,
  output logic              tx,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              tx_busy,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_overrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic [DIV_W-1:0] cnt;
  logic tick;
  assign tick = cnt >= baud_div;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  state_t tx_st;
  logic [DATA_W-1:0] tx_sh;
  logic [TW-1:0] tx_t;
  logic [BW-1:0] tx_b;
  logic tx_par, tx_has_par, tx_two, tx_end;
  assign tx_end = tick && tx_t == T_LAST;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      tx_st <= IDLE;
      tx_sh <= '0;
      tx_t <= '0;
      tx_b <= '0;
      tx_par <= 1'b0;
      tx_has_par <= 1'b0;
      tx_two <= 1'b0;
      tx <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      if (tick && tx_st != IDLE) tx_t <= tx_end ? '0 : tx_t + 1'b1;
      case (tx_st)
        IDLE:
          if (!tx_busy) begin
            if (wr_en) begin
              tx_busy <= 1'b1;
              tx_sh <= wr_data;
              tx_par <= ^wr_data ^ parity_mode[1];
              tx_has_par <= ^parity_mode;
              tx_two <= stop2;
            end
          end else if (tick) begin
            tx_st <= START;
            tx <= 1'b0;
            tx_t <= '0;
          end
        START:
          if (tx_end) begin
            tx_st <= DATA;
            tx <= tx_sh[0];
            tx_sh <= tx_sh >> 1;
            tx_b <= '0;
          end
        DATA:
          if (tx_end) begin
            if (tx_b == B_LAST) begin
              tx_st <= tx_has_par ? PARITY : STOP;
              tx <= tx_has_par ? tx_par : 1'b1;
              tx_b <= '0;
            end else begin
              tx <= tx_sh[0];
              tx_sh <= tx_sh >> 1;
              tx_b <= tx_b + 1'b1;
            end
          end
        PARITY:
          if (tx_end) begin
            tx_st <= STOP;
            tx <= 1'b1;
          end
        STOP:
          if (tx_end) begin
            if (tx_two && !tx_b[0]) tx_b[0] <= 1'b1;
            else begin
              tx_st <= IDLE;
              tx_busy <= 1'b0;
            end
          end
        default: tx_st <= IDLE;
      endcase
    end
  logic [1:0] rx_sync;
  logic rx_prev, rx_s;
  assign rx_s = rx_sync[1];
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_s;
    end
  state_t rx_st;
  logic [DATA_W-1:0] rx_sh;
  logic [TW-1:0] rx_t;
  logic [BW-1:0] rx_b;
  logic rx_has_par, rx_odd, rx_pbit, rx_done, rx_pe, rx_fe, rx_end;
  assign rx_end = tick && rx_t == T_LAST;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      rx_st <= IDLE;
      rx_sh <= '0;
      rx_t <= '0;
      rx_b <= '0;
      rx_has_par <= 1'b0;
      rx_odd <= 1'b0;
      rx_pbit <= 1'b0;
      rx_done <= 1'b0;
      rx_pe <= 1'b0;
      rx_fe <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (tick && rx_st != IDLE) rx_t <= rx_end ? '0 : rx_t + 1'b1;
      case (rx_st)
        IDLE:
          if (rx_prev && !rx_s) begin
            rx_st <= START;
            rx_t <= '0;
          end
        START:
          if (tick && rx_t == T_HALF) begin
            rx_st <= rx_s ? IDLE : DATA;
            rx_t <= '0;
            rx_b <= '0;
            rx_has_par <= ^parity_mode;
            rx_odd <= parity_mode[1];
          end
        DATA:
          if (rx_end) begin
            rx_sh <= {rx_s, rx_sh[DATA_W-1:1]};
            rx_b <= rx_b + 1'b1;
            if (rx_b == B_LAST) rx_st <= rx_has_par ? PARITY : STOP;
          end
        PARITY:
          if (rx_end) begin
            rx_pbit <= rx_s;
            rx_st <= STOP;
          end
        STOP:
          if (rx_end) begin
            rx_st <= IDLE;
            rx_done <= 1'b1;
            rx_fe <= !rx_s;
            rx_pe <= rx_has_par && (^rx_sh ^ rx_pbit ^ rx_odd);
          end
        default: rx_st <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_valid <= rx_done || (rx_valid && !rx_ready);
      rx_overrun <= rx_done && rx_valid && !rx_ready;
      rx_data <= rx_done ? rx_sh : rx_data;
      rx_parity_err <= rx_done ? rx_pe : rx_parity_err;
      rx_frame_err <= rx_done ? rx_fe : rx_frame_err;
    end
endmodule

// File: tb/tb_uart_core_cfg.sv
// tb_uart_core_cfg: table, directed and random checks of uart_core_cfg against a frame-level model
module tb_uart_core_cfg;
  localparam int OS = 16;
  logic clk = 0, rstb = 0;
  logic [15:0] baud_div = 16'd1;
  logic [1:0] parity_mode = 2'b00;
  logic stop2 = 0, rx_drv = 1, loop = 0, wr_en = 0, rx_ready = 0;
  logic [7:0] wr_data = 8'h00;
  logic tx, tx_busy, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_w;
  logic [7:0] rx_data;
  int n_chk = 0, n_fail = 0;
  assign rx_w = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  uart_core_cfg #(.DATA_W(8), .OVERSAMPLE(OS), .DIV_W(16)) dut (
    .clk(clk), .rstb(rstb), .baud_div(baud_div), .parity_mode(parity_mode),
    .stop2(stop2), .rx(rx_w), .tx(tx), .wr_en(wr_en), .wr_data(wr_data),
    .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );
  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic bad_par;
    logic stop_v;
    logic [7:0] exp_d;
    logic exp_pe;
    logic exp_fe;
  } vec_t;
  vec_t tbl[9];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  // Serial frame as the line carries it: start, LSB-first data, optional parity, stop bit(s)
  function automatic void mk_frame(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                                   input logic bad_par, input logic stop_v,
                                   output logic [15:0] b, output int n);
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1 + i] = d[i];
    n = 9;
    if (pm == 2'b01 || pm == 2'b10) begin
      b[n] = (($countones(d) % 2) == 1) ^ (pm == 2'b10) ^ bad_par;
      n++;
    end
    b[n] = stop_v;
    n++;
    if (s2) begin
      b[n] = 1'b1;
      n++;
    end
  endfunction
  task automatic write(input logic [7:0] d);
    @(negedge clk);
    wr_en = 1;
    wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask
  task automatic check_tx_frame(input string nm, input logic [15:0] b, input int n, input int bclk);
    int to = 0;
    int bad;
    while (tx !== 1'b0 && to < 5000) begin
      @(negedge clk);
      to++;
    end
    check({nm, "_start"}, tx, 1'b0);
    for (int i = 0; i < n; i++) begin
      bad = 0;
      for (int j = 0; j < bclk; j++) begin
        if (tx !== b[i]) bad++;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d_wrong_clocks", nm, i), bad, 0);
    end
    check({nm, "_busy_end"}, tx_busy, 1'b0);
    check({nm, "_idle_tx"}, tx, 1'b1);
  endtask
  task automatic send_rx(input logic [15:0] b, input int n, input int bclk);
    for (int i = 0; i < n; i++) begin
      rx_drv = b[i];
      repeat (bclk) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask
  task automatic wait_rx(input string nm, input logic [7:0] d, input logic pe, input logic fe);
    int to = 0;
    while (rx_valid !== 1'b1 && to < 3000) begin
      @(negedge clk);
      to++;
    end
    check({nm, "_valid"}, rx_valid, 1'b1);
    check({nm, "_data"}, rx_data, d);
    check({nm, "_parity_err"}, rx_parity_err, pe);
    check({nm, "_frame_err"}, rx_frame_err, fe);
    rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
    check({nm, "_cleared"}, rx_valid, 1'b0);
    check({nm, "_hold"}, rx_data, d);
  endtask
  initial begin
    logic [15:0] b, b2;
    int n, n2, ovc;
    tbl[0] = '{8'h00, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 2'b01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[2] = '{8'h01, 2'b10, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[3] = '{8'h7E, 2'b01, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0};
    tbl[4] = '{8'hC3, 2'b10, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1};
    tbl[5] = '{8'h5A, 2'b00, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
    tbl[6] = '{8'h80, 2'b11, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[7] = '{8'hAA, 2'b10, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0};
    tbl[8] = '{8'h81, 2'b10, 1'b1, 1'b0, 8'h81, 1'b1, 1'b1};
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 8'h00);
    check("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 3'b000);
    rstb = 1;
    repeat (3) @(negedge clk);
    // 8N1 at baud_div=1: 32 clocks per bit, a mid-frame write must be ignored
    mk_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, b, n);
    write(8'hA5);
    fork
      check_tx_frame("n81", b, n, 32);
      begin
        int bc = 0, lc = 0;
        bit st = 0;
        for (int k = 0; k < 2000; k++) begin
          if (!tx_busy && bc > 0) break;
          if (tx_busy) bc++;
          if (tx_busy && !st) begin
            if (tx === 1'b0) st = 1;
            else lc++;
          end
          @(negedge clk);
        end
        check("n81_busy_minus_latency", bc - lc, 320);
        check("n81_latency_in_range", (lc >= 1 && lc <= 3), 1'b1);
      end
      begin
        repeat (100) @(negedge clk);
        wr_en = 1;
        wr_data = 8'hFF;
        @(negedge clk);
        wr_en = 0;
      end
    join
    repeat (50) @(negedge clk);
    check("n81_ignored_write", {tx_busy, tx}, 2'b01);
    // Reset in the middle of data bits of an all-zero frame
    write(8'h00);
    begin
      int to = 0;
      while (tx !== 1'b0 && to < 500) begin
        @(negedge clk);
        to++;
      end
    end
    repeat (32 * 3 + 10) @(negedge clk);
    check("pre_rst_tx_low", tx, 1'b0);
    #2 rstb = 0;
    #1;
    check("async_rst_tx", tx, 1'b1);
    check("async_rst_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    rstb = 1;
    mk_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, b, n);
    write(8'h5A);
    check_tx_frame("post_rst", b, n, 32);
    // 8E2 loopback
    loop = 1;
    parity_mode = 2'b01;
    stop2 = 1;
    mk_frame(8'h3C, 2'b01, 1'b1, 1'b0, 1'b1, b, n);
    check("e82_frame_len", n, 12);
    write(8'h3C);
    check_tx_frame("e82", b, n, 32);
    wait_rx("e82_rx", 8'h3C, 1'b0, 1'b0);
    loop = 0;
    stop2 = 0;
    // Table of bench-built RX frames, including corrupted parity and stop bits
    for (int i = 0; i < 9; i++) begin
      parity_mode = tbl[i].pm;
      mk_frame(tbl[i].d, tbl[i].pm, 1'b0, tbl[i].bad_par, tbl[i].stop_v, b, n);
      send_rx(b, n, 32);
      wait_rx($sformatf("tbl%0d", i), tbl[i].exp_d, tbl[i].exp_pe, tbl[i].exp_fe);
    end
    // Start glitch shorter than half a bit is rejected, then a normal frame
    parity_mode = 2'b00;
    repeat (64) @(negedge clk);
    rx_drv = 0;
    repeat ((OS / 2 - 2) * 2) @(negedge clk);
    rx_drv = 1;
    repeat (400) @(negedge clk);
    check("glitch_no_valid", rx_valid, 1'b0);
    mk_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, b, n);
    send_rx(b, n, 32);
    wait_rx("glitch_follow", 8'h55, 1'b0, 1'b0);
    // Overrun: two back-to-back frames with rx_ready held low
    mk_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, b, n);
    mk_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, b2, n2);
    ovc = 0;
    fork
      begin
        send_rx(b, n, 32);
        send_rx(b2, n2, 32);
      end
      for (int k = 0; k < 700; k++) begin
        @(negedge clk);
        if (rx_overrun) ovc++;
      end
    join
    check("ovr_pulses", ovc, 1);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_data", rx_data, 8'h22);
    rx_ready = 1;
    @(negedge clk);
    rx_ready = 0;
    check("ovr_cleared", rx_valid, 1'b0);
    check("ovr_pulse_gone", rx_overrun, 1'b0);
    // Random frames: loopback through TX, or bench-driven RX with random faults
    for (int r = 0; r < 14; r++) begin
      logic [7:0] d;
      logic [1:0] pm;
      logic s2, bp, sv;
      int bclk;
      d = 8'($urandom);
      pm = 2'($urandom);
      s2 = 1'($urandom);
      baud_div = 16'($urandom_range(0, 3));
      bclk = OS * (int'(baud_div) + 1);
      parity_mode = pm;
      stop2 = s2;
      if ($urandom_range(0, 1) == 1) begin
        loop = 1;
        mk_frame(d, pm, s2, 1'b0, 1'b1, b, n);
        write(d);
        check_tx_frame($sformatf("rnd%0d_tx", r), b, n, bclk);
        wait_rx($sformatf("rnd%0d_loop", r), d, 1'b0, 1'b0);
        loop = 0;
      end else begin
        bp = 1'($urandom);
        sv = 1'($urandom);
        mk_frame(d, pm, s2, bp, sv, b, n);
        send_rx(b, n, bclk);
        wait_rx($sformatf("rnd%0d_rx", r), d, (pm == 2'b01 || pm == 2'b10) && bp, !sv);
      end
      repeat (20) @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
